// File: rtl/bip_pkg.sv
// bip_pkg: shared opcode, state, instruction-class and datapath-mux encodings
// for the BIP control unit.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM_WAIT, ST_HALT} state_t;

  typedef enum logic [2:0] {CLS_IMM, CLS_RD, CLS_WR, CLS_BR, CLS_HLT, CLS_ILL} cls_t;

  typedef enum logic [1:0] {BR_ALWAYS, BR_ZERO, BR_NZERO} br_t;

  localparam logic [1:0] SEL_RAM = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: classifies the IR opcode and selects the accumulator/ALU mux
// settings used while that instruction executes.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NBITS_OPCODE = 5
) (
  input  logic [NBITS_OPCODE-1:0] opcode,
  output cls_t                    cls,
  output br_t                     br,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic                    op
);

  always_comb begin
    cls   = CLS_ILL;
    br    = BR_ALWAYS;
    sel_a = SEL_RAM;
    sel_b = 1'b0;
    op    = ALU_ADD;
    case (opcode)
      NBITS_OPCODE'(OP_HLT):  cls = CLS_HLT;
      NBITS_OPCODE'(OP_STO):  cls = CLS_WR;
      NBITS_OPCODE'(OP_LD):   cls = CLS_RD;
      NBITS_OPCODE'(OP_LDI): begin
        cls   = CLS_IMM;
        sel_a = SEL_IMM;
      end
      NBITS_OPCODE'(OP_ADD): begin
        cls   = CLS_RD;
        sel_a = SEL_ALU;
      end
      NBITS_OPCODE'(OP_ADDI): begin
        cls   = CLS_IMM;
        sel_a = SEL_ALU;
        sel_b = 1'b1;
      end
      NBITS_OPCODE'(OP_SUB): begin
        cls   = CLS_RD;
        sel_a = SEL_ALU;
        op    = ALU_SUB;
      end
      NBITS_OPCODE'(OP_SUBI): begin
        cls   = CLS_IMM;
        sel_a = SEL_ALU;
        sel_b = 1'b1;
        op    = ALU_SUB;
      end
      NBITS_OPCODE'(OP_JMP):  cls = CLS_BR;
      NBITS_OPCODE'(OP_BEQ): begin
        cls = CLS_BR;
        br  = BR_ZERO;
      end
      NBITS_OPCODE'(OP_BNE): begin
        cls = CLS_BR;
        br  = BR_NZERO;
      end
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/bip_control_seq.sv
// bip_control_seq: BIP control unit -- fetch/execute/memory-wait/halt FSM with
// PC, instruction register, branches and a retired-instruction counter.
module bip_control_seq
  import bip_pkg::*;
#(
  parameter int          NBITS_ADDR   = 11,
  parameter int          NBITS_INSTR  = 16,
  parameter int          NBITS_OPCODE = 5,
  parameter int unsigned RESET_PC     = 0,
  parameter int          NBITS_CNT    = 32
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NBITS_INSTR-1:0]          i_Instruction,
  input  logic                            i_InstrValid,
  input  logic                            i_MemReady,
  input  logic                            i_AccZero,
  output logic [NBITS_ADDR-1:0]           o_Addr,
  output logic                            o_InstrReq,
  output logic [1:0]                      o_SelA,
  output logic                            o_SelB,
  output logic                            o_WrAcc,
  output logic                            o_Op,
  output logic                            o_WrRam,
  output logic                            o_RdRam,
  output logic [NBITS_INSTR-NBITS_OPCODE-1:0] o_Operand,
  output logic [NBITS_OPCODE-1:0]         o_Opcode,
  output logic                            o_Halt,
  output logic                            o_Illegal,
  output logic [NBITS_CNT-1:0]            o_InstrCount
);

  localparam int NBITS_OPND = NBITS_INSTR - NBITS_OPCODE;

  if (NBITS_OPND < NBITS_ADDR) begin : g_width_check
    $error("bip_control_seq: operand field narrower than program address");
  end

  state_t                 state, state_d;
  logic [NBITS_ADDR-1:0]  pc, pc_d;
  logic [NBITS_INSTR-1:0] ir;
  logic [NBITS_CNT-1:0]   cnt;
  logic                   load_ir, retire;
  cls_t                   cls;
  br_t                    br;
  logic [1:0]             dec_sel_a;
  logic                   dec_sel_b, dec_op;
  logic                   mem, take;
  logic [NBITS_ADDR-1:0]  pc_inc, target;

  assign o_Opcode     = ir[NBITS_INSTR-1 -: NBITS_OPCODE];
  assign o_Operand    = ir[NBITS_OPND-1:0];
  assign o_Addr       = pc;
  assign o_InstrCount = cnt;

  bip_decoder #(.NBITS_OPCODE(NBITS_OPCODE)) u_dec (
    .opcode (o_Opcode),
    .cls    (cls),
    .br     (br),
    .sel_a  (dec_sel_a),
    .sel_b  (dec_sel_b),
    .op     (dec_op)
  );

  assign mem    = (cls == CLS_RD) || (cls == CLS_WR);
  assign pc_inc = pc + NBITS_ADDR'(1);
  assign target = o_Operand[NBITS_ADDR-1:0];
  assign take   = (br == BR_ALWAYS) || ((br == BR_ZERO) == i_AccZero);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_FETCH;
      pc    <= NBITS_ADDR'(RESET_PC);
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (load_ir) ir <= i_Instruction;
      if (retire) cnt <= cnt + NBITS_CNT'(1);
    end
  end

  // RAM strobes and mux selects stay asserted from EXEC through the MEM_WAIT
  // completion cycle; i_MemReady is only honoured once in MEM_WAIT.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    load_ir    = 1'b0;
    retire     = 1'b0;
    o_InstrReq = 1'b0;
    o_WrAcc    = 1'b0;
    o_WrRam    = 1'b0;
    o_RdRam    = 1'b0;
    o_Illegal  = 1'b0;
    o_Halt     = 1'b0;
    o_SelA     = SEL_RAM;
    o_SelB     = 1'b0;
    o_Op       = ALU_ADD;
    case (state)
      ST_FETCH: begin
        o_InstrReq = 1'b1;
        load_ir    = i_InstrValid;
        state_d    = i_InstrValid ? ST_EXEC : ST_FETCH;
      end
      ST_EXEC: begin
        o_SelA    = dec_sel_a;
        o_SelB    = dec_sel_b;
        o_Op      = dec_op;
        o_RdRam   = cls == CLS_RD;
        o_WrRam   = cls == CLS_WR;
        o_WrAcc   = cls == CLS_IMM;
        o_Illegal = cls == CLS_ILL;
        retire    = !mem;
        state_d   = mem ? ST_MEM_WAIT : (cls == CLS_HLT) ? ST_HALT : ST_FETCH;
        pc_d      = (mem || cls == CLS_HLT) ? pc : (cls == CLS_BR && take) ? target : pc_inc;
      end
      ST_MEM_WAIT: begin
        o_SelA  = dec_sel_a;
        o_SelB  = dec_sel_b;
        o_Op    = dec_op;
        o_RdRam = cls == CLS_RD;
        o_WrRam = cls == CLS_WR;
        o_WrAcc = i_MemReady && cls == CLS_RD;
        retire  = i_MemReady;
        pc_d    = i_MemReady ? pc_inc : pc;
        state_d = i_MemReady ? ST_FETCH : ST_MEM_WAIT;
      end
      default: o_Halt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bip_control_seq.sv
// tb_bip_control_seq: table-driven instruction vectors with a scoreboard queue,
// plus hand-written reset, stall and halt sequences.
module tb_bip_control_seq;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_Instruction;
  logic        i_InstrValid;
  logic        i_MemReady;
  logic        i_AccZero;
  logic [10:0] o_Addr;
  logic        o_InstrReq;
  logic [1:0]  o_SelA;
  logic        o_SelB;
  logic        o_WrAcc;
  logic        o_Op;
  logic        o_WrRam;
  logic        o_RdRam;
  logic [10:0] o_Operand;
  logic [4:0]  o_Opcode;
  logic        o_Halt;
  logic        o_Illegal;
  logic [31:0] o_InstrCount;

  always #5 i_clk = ~i_clk;

  bip_control_seq dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_Instruction (i_Instruction),
    .i_InstrValid  (i_InstrValid),
    .i_MemReady    (i_MemReady),
    .i_AccZero     (i_AccZero),
    .o_Addr        (o_Addr),
    .o_InstrReq    (o_InstrReq),
    .o_SelA        (o_SelA),
    .o_SelB        (o_SelB),
    .o_WrAcc       (o_WrAcc),
    .o_Op          (o_Op),
    .o_WrRam       (o_WrRam),
    .o_RdRam       (o_RdRam),
    .o_Operand     (o_Operand),
    .o_Opcode      (o_Opcode),
    .o_Halt        (o_Halt),
    .o_Illegal     (o_Illegal),
    .o_InstrCount  (o_InstrCount)
  );

  // lat: MEM_WAIT-relative cycle index at which i_MemReady is raised (1 = first wait cycle)
  typedef struct {
    logic [15:0] instr;
    logic        zero;
    int          lat;
    int          e_rd;
    int          e_wr;
    int          e_wacc;
    logic [1:0]  e_sel;
    logic        e_selb;
    logic        e_op;
    int          e_ill;
    logic        e_halt;
    logic [10:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    int          rd;
    int          wr;
    int          wacc;
    int          ill;
    logic [1:0]  sel;
    logic        selb;
    logic        op;
    logic        halt;
    logic [10:0] pc;
    logic [31:0] cnt;
  } obs_t;

  vec_t  sb[$];
  vec_t  tbl[16];
  int    checks = 0;
  int    errors = 0;
  string tag = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 'h%0h, expected 'h%0h", tag, name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset      = 1'b0;
    i_InstrValid = 1'b0;
    i_MemReady   = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    obs_t o;
    vec_t e;
    bit   done = 0;
    o = '{default: 0};
    sb.push_back(v);
    tag           = $sformatf("instr=%h@%h", v.instr, o_Addr);
    i_Instruction = v.instr;
    i_AccZero     = v.zero;
    i_InstrValid  = 1'b1;
    i_MemReady    = 1'b0;
    @(negedge i_clk);
    chk("fetch_req", 32'(o_InstrReq), 1);
    @(posedge i_clk);
    #1;
    i_InstrValid  = 1'b0;
    i_Instruction = 16'($urandom);
    for (int k = 0; k < 40 && !done; k++) begin
      i_MemReady = (k == 0) || (k >= v.lat);
      @(negedge i_clk);
      o.rd  += int'(o_RdRam);
      o.wr  += int'(o_WrRam);
      o.ill += int'(o_Illegal);
      if (o_WrAcc) begin
        o.wacc++;
        o.sel  = o_SelA;
        o.selb = o_SelB;
        o.op   = o_Op;
      end
      @(posedge i_clk);
      #1;
      done = o_InstrReq || o_Halt;
    end
    i_MemReady = 1'b0;
    o.pc   = o_Addr;
    o.cnt  = o_InstrCount;
    o.halt = o_Halt;
    e = sb.pop_front();
    chk("complete", 32'(done), 1);
    chk("rd_cycles", o.rd, e.e_rd);
    chk("wr_cycles", o.wr, e.e_wr);
    chk("wracc_cycles", o.wacc, e.e_wacc);
    chk("illegal_cycles", o.ill, e.e_ill);
    chk("halt", 32'(o.halt), 32'(e.e_halt));
    chk("next_pc", 32'(o.pc), 32'(e.e_pc));
    chk("count", o.cnt, e.e_cnt);
    if (e.e_wacc > 0) chk("sel_a", 32'(o.sel), 32'(e.e_sel));
    if (e.e_wacc > 0 && e.e_sel == 2'd2) begin
      chk("sel_b", 32'(o.selb), 32'(e.e_selb));
      chk("alu_op", 32'(o.op), 32'(e.e_op));
    end
  endtask

  task automatic halt_hold(input logic [10:0] pc_exp);
    int strobes = 0;
    int halted  = 0;
    int bad_pc  = 0;
    tag           = "halt_hold";
    i_InstrValid  = 1'b1;
    i_MemReady    = 1'b1;
    i_Instruction = 16'h1805;
    repeat (20) begin
      @(negedge i_clk);
      strobes += int'(o_InstrReq | o_WrAcc | o_WrRam | o_RdRam | o_Illegal);
      halted  += int'(o_Halt);
      bad_pc  += int'(o_Addr !== pc_exp);
    end
    @(posedge i_clk);
    #1;
    i_InstrValid = 1'b0;
    i_MemReady   = 1'b0;
    chk("strobes_during_halt", strobes, 0);
    chk("halt_cycles", halted, 20);
    chk("pc_moved_in_halt", bad_pc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{16'h1805, 1'b0, 1, 0, 0, 1, 2'd1, 1'b0, 1'b0, 0, 1'b0, 11'h001, 32'd1};
    tbl[1]  = '{16'h2803, 1'b0, 1, 0, 0, 1, 2'd2, 1'b1, 1'b0, 0, 1'b0, 11'h002, 32'd2};
    tbl[2]  = '{16'h3801, 1'b0, 1, 0, 0, 1, 2'd2, 1'b1, 1'b1, 0, 1'b0, 11'h003, 32'd3};
    tbl[3]  = '{16'h1010, 1'b0, 3, 4, 0, 1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h004, 32'd4};
    tbl[4]  = '{16'h2011, 1'b0, 1, 2, 0, 1, 2'd2, 1'b0, 1'b0, 0, 1'b0, 11'h005, 32'd5};
    tbl[5]  = '{16'h47FF, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h7FF, 32'd6};
    tbl[6]  = '{16'h1800, 1'b0, 1, 0, 0, 1, 2'd1, 1'b0, 1'b0, 0, 1'b0, 11'h000, 32'd7};
    tbl[7]  = '{16'h3012, 1'b0, 2, 3, 0, 1, 2'd2, 1'b0, 1'b1, 0, 1'b0, 11'h001, 32'd8};
    tbl[8]  = '{16'h0820, 1'b0, 1, 0, 2, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h002, 32'd9};
    tbl[9]  = '{16'h4900, 1'b1, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h100, 32'd10};
    tbl[10] = '{16'h4A00, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h101, 32'd11};
    tbl[11] = '{16'h5300, 1'b1, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h102, 32'd12};
    tbl[12] = '{16'h5300, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 11'h300, 32'd13};
    tbl[13] = '{16'hF800, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 1, 1'b0, 11'h301, 32'd14};
    tbl[14] = '{16'h5800, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 1, 1'b0, 11'h302, 32'd15};
    tbl[15] = '{16'h0000, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b1, 11'h302, 32'd16};

    i_reset       = 1'b0;
    i_Instruction = 16'h0;
    i_InstrValid  = 1'b0;
    i_MemReady    = 1'b0;
    i_AccZero     = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    tag = "reset";
    chk("addr", 32'(o_Addr), 0);
    chk("req", 32'(o_InstrReq), 1);
    chk("count", o_InstrCount, 0);
    chk("strobes", 32'({o_WrAcc, o_WrRam, o_RdRam, o_Illegal, o_Halt}), 0);
    chk("opcode", 32'(o_Opcode), 0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) run(tbl[i]);
    halt_hold(11'h302);

    do_reset();
    tag           = "stall_ir0";
    i_Instruction = 16'h1805;
    repeat (5) begin
      @(negedge i_clk);
      chk("req", 32'(o_InstrReq), 1);
      chk("addr", 32'(o_Addr), 0);
      chk("opcode", 32'(o_Opcode), 0);
      @(posedge i_clk);
      #1;
    end
    v = '{16'h1807, 1'b0, 1, 0, 0, 1, 2'd1, 1'b0, 1'b0, 0, 1'b0, 11'h001, 32'd1};
    run(v);
    tag           = "stall_ir_ldi7";
    i_Instruction = 16'hF8AA;
    repeat (5) begin
      @(negedge i_clk);
      chk("req", 32'(o_InstrReq), 1);
      chk("addr", 32'(o_Addr), 1);
      chk("opcode", 32'(o_Opcode), 3);
      chk("operand", 32'(o_Operand), 7);
      @(posedge i_clk);
      #1;
    end

    tag           = "sto_reset";
    i_Instruction = 16'h0820;
    i_InstrValid  = 1'b1;
    i_MemReady    = 1'b0;
    @(posedge i_clk);
    #1;
    i_InstrValid = 1'b0;
    @(negedge i_clk);
    chk("exec_wr", 32'(o_WrRam), 1);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("wait_wr", 32'(o_WrRam), 1);
    #1 i_reset = 1'b0;
    #1;
    chk("async_wr_drop", 32'(o_WrRam), 0);
    chk("async_req", 32'(o_InstrReq), 1);
    chk("async_addr", 32'(o_Addr), 0);
    chk("async_count", o_InstrCount, 0);
    i_MemReady = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset    = 1'b1;
    i_MemReady = 1'b0;
    @(posedge i_clk);
    #1;
    chk("post_addr", 32'(o_Addr), 0);
    chk("post_req", 32'(o_InstrReq), 1);
    chk("post_count", o_InstrCount, 0);
    chk("post_wr", 32'(o_WrRam), 0);

    v = '{16'h1805, 1'b0, 1, 0, 0, 1, 2'd1, 1'b0, 1'b0, 0, 1'b0, 11'h001, 32'd1};
    run(v);
    v = '{16'h2803, 1'b0, 1, 0, 0, 1, 2'd2, 1'b1, 1'b0, 0, 1'b0, 11'h002, 32'd2};
    run(v);
    v = '{16'h0000, 1'b0, 1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 0, 1'b1, 11'h002, 32'd3};
    run(v);
    halt_hold(11'h002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_control_seq.md
Name: bip_control_seq

Overview:
- Next-generation control unit for the BIP accumulator processor.
- Sequences the fetch/execute flow with a FETCH/EXEC/MEM_WAIT/HALT state machine.
- Holds the instruction register, PC, HALT logic and a retired-instruction counter.
- Adds absolute branches (JMP/BEQ/BNE), handshakes with instruction and data memory, and flags illegal opcodes. Sits between program memory, data RAM and the datapath (accumulator/ALU muxes).

Parameters:
NBITS_ADDR, 11, PC / program-address width
NBITS_INSTR, 16, instruction width
NBITS_OPCODE, 5, opcode field width (MSBs of instruction)
RESET_PC, 0, PC value loaded on reset
NBITS_CNT, 32, retired-instruction counter width

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_Instruction  in  NBITS_INSTR  instruction word from program memory
i_InstrValid  in  1  program memory word valid for o_Addr
i_MemReady  in  1  data RAM completed current read/write
i_AccZero  in  1  accumulator == 0 (datapath flag)
o_Addr  out  NBITS_ADDR  program address (PC)
o_InstrReq  out  1  fetch request
o_SelA  out  2  accumulator source: 0 RAM, 1 immediate, 2 ALU
o_SelB  out  1  ALU operand B: 0 RAM, 1 immediate
o_WrAcc  out  1  accumulator write enable
o_Op  out  1  ALU op: 0 add, 1 sub
o_WrRam  out  1  RAM write strobe
o_RdRam  out  1  RAM read strobe
o_Operand  out  NBITS_INSTR-NBITS_OPCODE  operand field of IR
o_Opcode  out  NBITS_OPCODE  opcode field of IR
o_Halt  out  1  processor halted
o_Illegal  out  1  one-cycle pulse on undefined opcode
o_InstrCount  out  NBITS_CNT  instructions retired

Behaviour:
- Reset (i_reset=0, async):
  - State FETCH, PC=RESET_PC, IR=0, counter=0.
  - All strobes 0, o_Halt=0, o_Illegal=0.
  - A reset mid-operation aborts any pending RAM access; no write completes after reset assertion.
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, JMP 01000, BEQ 01001, BNE 01010. All others are illegal.
- FETCH:
  - o_InstrReq=1.
  - When i_InstrValid=1, IR<=i_Instruction and go to EXEC. Otherwise stay, PC stable.
- EXEC (control decoded from IR, combinational from state+IR):
  - LDI/ADDI/SUBI: single cycle.
    - LDI: SelA=1, WrAcc=1.
    - ADDI: SelA=2, SelB=1, Op=0, WrAcc=1.
    - SUBI: as ADDI with Op=1.
  - LD/ADD/SUB: RdRam=1, go to MEM_WAIT.
  - STO: WrRam=1, go to MEM_WAIT.
  - JMP: PC<=operand[NBITS_ADDR-1:0].
  - BEQ: jump if i_AccZero=1, else PC+1.
  - BNE: jump if i_AccZero=0, else PC+1.
  - HLT: go to HALT; PC not incremented.
  - Illegal: o_Illegal=1 for this cycle; executes as a NOP, PC+1.
  - Every non-memory, non-HLT instruction returns to FETCH with the PC updated and the counter incremented.
- MEM_WAIT:
  - Strobe (RdRam or WrRam) and SelA/SelB/Op held stable.
  - On the cycle i_MemReady=1:
    - LD: WrAcc=1, SelA=0.
    - ADD/SUB: WrAcc=1, SelA=2, SelB=0.
    - STO: no accumulator write.
    - PC+1, counter+1, go to FETCH.
  - i_MemReady already high in the EXEC cycle is ignored; completion is sampled only in MEM_WAIT. Minimum memory instruction length is 3 cycles including FETCH.
- HALT: o_Halt=1, all strobes 0, sticky until reset. HLT counts as retired.
- PC increment wraps from 2^NBITS_ADDR-1 to 0. Jump targets above the PC width are truncated.
- o_InstrCount wraps at 2^NBITS_CNT.
- Latency: zero-wait immediate op is 2 cycles (FETCH+EXEC).
- Constraint: NBITS_INSTR-NBITS_OPCODE >= NBITS_ADDR (elaboration check).

Decomposition:
- Shared package bip_pkg:
  - opcode localparams;
  - state encoding (FETCH, EXEC, MEM_WAIT, HALT);
  - SelA codes (SEL_RAM, SEL_IMM, SEL_ALU);
  - ALU op codes.
- Sub-module bip_decoder: combinational IR opcode -> class (imm/mem-read/mem-write/branch/halt/illegal) plus SelA/SelB/Op.
- The FSM, PC, IR and counter live in bip_control_seq.

Test Plan:
1. Reset low mid-MEM_WAIT of STO (WrRam=1) -> WrRam drops asynchronously. After release: PC=0, state FETCH, o_InstrCount=0.
2. Program at 0: LDI 5 / ADDI 3 / HLT with i_InstrValid=1 -> WrAcc pulses with SelA=1 then SelA=2/SelB=1/Op=0. Then o_Halt=1, PC=2, count=3, and strobes stay 0 for 20 cycles.
3. LD 0x10 with i_MemReady delayed 3 cycles -> RdRam high 4 consecutive cycles, WrAcc=1 only in the last cycle with SelA=0. PC advances by 1.
4. BEQ 0x100: i_AccZero=1 gives next o_Addr=0x100. i_AccZero=0 gives PC+1. BNE gives the opposite results. JMP 0x7FF at PC=5 gives PC=0x7FF, then the next sequential instruction wraps PC to 0.
5. Opcode 11111 -> o_Illegal high exactly 1 cycle, no RAM/Acc strobes, PC+1, count+1.
6. i_InstrValid held low 5 cycles -> o_InstrReq high throughout, o_Addr stable, IR unchanged.
